// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, change detector and tick-gated reload counter.
// Optional registered edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_bank #(
    parameter int CHANNELS    = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [CNT_W-1:0]    reload,
    input  logic                tick,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

`ifdef DEBOUNCE_EDGE_EN
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        logic                   s_d;
        logic                   chg;
        logic                   settled;
        logic                   out_q;
        logic [CNT_W-1:0]       cnt;

        assign s       = sync[SYNC_STAGES-1];
        assign chg     = s ^ s_d;
        assign settled = (cnt == '0) && !chg;

        // A fresh change always reloads, even when tick is high in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync  <= '0;
                s_d   <= 1'b0;
                cnt   <= '0;
                out_q <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], in[i]};
                s_d  <= s;
                if (chg)
                    cnt <= reload;
                else if ((cnt != '0) && tick)
                    cnt <= cnt - CNT_W'(1);
                if (settled)
                    out_q <= s_d;
            end
        end

        assign out[i]  = out_q;
        assign busy[i] = (cnt != '0);

`ifdef DEBOUNCE_EDGE_EN
        assign rise_nxt[i] = settled && s_d && !out_q;
        assign fall_nxt[i] = settled && !s_d && out_q;
`endif
    end

`ifdef DEBOUNCE_EDGE_EN
    // Pulses are registered alongside out so they line up with the level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
        end
    end
`else
    assign rise       = '0;
    assign fall       = '0;
    assign any_change = 1'b0;
`endif

endmodule
